// File: rtl/typhoon_pkg.sv
// Shared types and defaults for the vertex projection stream.
//   world_vert_t  : one world-space vertex {x, y, z}, signed
//   raster_vert_t : one projected vertex {sx, sy, depth}, unsigned
//   bbox_t        : bin bounding box {x_min, x_max, y_min, y_max}
//   state_t       : projector FSM states
// The typedefs describe the default geometry; the top level is parametrised
// and slices its flat ports directly, so these types fit only the default
// widths.
package typhoon_pkg;

  localparam int WC_W_DEF      = 21;
  localparam int XY_W_DEF      = 10;
  localparam int Z_W_DEF       = 16;
  localparam int BIN_SHIFT_DEF = 3;
  localparam int BIN_W_DEF     = XY_W_DEF - BIN_SHIFT_DEF;

  typedef struct packed {
    logic signed [WC_W_DEF-1:0] x;
    logic signed [WC_W_DEF-1:0] y;
    logic signed [WC_W_DEF-1:0] z;
  } world_vert_t;

  typedef struct packed {
    logic [XY_W_DEF-1:0] sx;
    logic [XY_W_DEF-1:0] sy;
    logic [Z_W_DEF-1:0]  depth;
  } raster_vert_t;

  typedef struct packed {
    logic [BIN_W_DEF-1:0] x_min;
    logic [BIN_W_DEF-1:0] x_max;
    logic [BIN_W_DEF-1:0] y_min;
    logic [BIN_W_DEF-1:0] y_max;
  } bbox_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BBOX,
    ST_OUT
  } state_t;

endpackage

// File: rtl/proj_divider.sv
// Pipelined signed divider, quotient truncated toward zero.
//   clk_i  : clock
//   num_i  : signed numerator
//   den_i  : signed denominator, never zero or negative in use
//   quo_o  : quotient of the operands presented DIV_LAT cycles earlier
// The divide is written as one combinational stage followed by DIV_LAT
// registers so that retiming can spread it across the pipeline. There is no
// handshake or valid tracking here; the caller tags issued operands itself.
module proj_divider #(
  parameter int WC_W    = 21,
  parameter int DIV_LAT = 3
) (
  input  logic                   clk_i,
  input  logic signed [WC_W-1:0] num_i,
  input  logic signed [WC_W-1:0] den_i,
  output logic signed [WC_W-1:0] quo_o
);

  logic signed [WC_W-1:0] pipe_q [DIV_LAT];

  always_ff @(posedge clk_i) begin
    pipe_q[0] <= num_i / den_i;
    for (int i = 1; i < DIV_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign quo_o = pipe_q[DIV_LAT-1];

endmodule

// File: rtl/vertex_project_stream.sv
// Streaming world-to-raster projector, one triangle at a time.
//   BOARD_CLK          : clock, posedge
//   reset              : synchronous, active-high
//   in_valid/in_ready  : world triangle handshake
//   in_vert            : in_vert[k] = vertex k {x, y, z}
//   in_last            : frame-end marker, returned on out_last
//   out_valid/out_ready: raster triangle handshake
//   out_vert           : out_vert[k] = vertex k {sx, sy, depth}
//   out_bbox           : {bin_x_min, bin_x_max, bin_y_min, bin_y_max}
//   out_cull           : triangle had a vertex with z <= 0; fields are zero
//   out_last           : in_last of this triangle
//
//  state | meaning
//  IDLE  | ready for a triangle; capture on in_valid
//  ISSUE | 3 cycles, feed vertex vidx_q to the x/y dividers
//  WAIT  | DIV_LAT cycles, drain the dividers
//  BBOX  | 1 cycle, reduce bins and load the output registers
//  OUT   | present result until out_ready
module vertex_project_stream
  import typhoon_pkg::*;
#(
  parameter int SCREEN_W  = 800,
  parameter int SCREEN_H  = 525,
  parameter int WC_W      = WC_W_DEF,
  parameter int XY_W      = XY_W_DEF,
  parameter int Z_W       = Z_W_DEF,
  parameter int Z_SHIFT   = 5,
  parameter int BIN_SHIFT = 3,
  parameter int DIV_LAT   = 3
) (
  input  logic                                BOARD_CLK,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [2:0][3*WC_W-1:0]              in_vert,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [2:0][2*XY_W+Z_W-1:0]          out_vert,
  output logic [4*(XY_W-BIN_SHIFT)-1:0]       out_bbox,
  output logic                                out_cull,
  output logic                                out_last
);

  localparam int VERT_W = 3 * WC_W;
  localparam int RV_W   = 2 * XY_W + Z_W;
  localparam int BIN_W  = XY_W - BIN_SHIFT;
  localparam int WT_W   = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam int ZS_W   = (WC_W > Z_W) ? WC_W : Z_W;

  localparam logic signed [WC_W:0] X_OFF  = (WC_W+1)'(SCREEN_W / 2);
  localparam logic signed [WC_W:0] Y_OFF  = (WC_W+1)'(SCREEN_H / 2);
  localparam logic signed [WC_W:0] XY_MAX = (WC_W+1)'((1 << XY_W) - 1);

  state_t                 state_q, state_d;
  logic [1:0]             vidx_q, vidx_d;
  logic [WT_W-1:0]        wait_q, wait_d;
  logic [2:0][VERT_W-1:0] world_q;
  logic                   last_q;
  logic [DIV_LAT-1:0]     tag_vld_q;
  logic [1:0]             tag_idx_q [DIV_LAT];
  logic [2:0][XY_W-1:0]   sx_q, sy_q;

  logic [2:0][RV_W-1:0]   out_vert_q;
  logic [4*BIN_W-1:0]     out_bbox_q;
  logic                   out_cull_q, out_last_q;

  logic                   any_z_nonpos;
  logic [VERT_W-1:0]      cur_vert;
  logic signed [WC_W-1:0] div_x, div_y, div_z, qx, qy;
  logic [2:0][BIN_W-1:0]  bx, by;
  logic [BIN_W-1:0]       bx_min, bx_max, by_min, by_max;
  logic [2:0][RV_W-1:0]   rv;

  // Offset at WC_W+1 bits so the sum cannot wrap before clamping.
  function automatic logic [XY_W-1:0] sat_xy(input logic signed [WC_W-1:0] q,
                                             input logic signed [WC_W:0]   off);
    logic signed [WC_W:0] s;
    s = signed'({q[WC_W-1], q}) + off;
    if (s[WC_W]) return '0;
    if (s > XY_MAX) return '1;
    return s[XY_W-1:0];
  endfunction

  function automatic logic [Z_W-1:0] depth_of(input logic [WC_W-1:0] z);
    logic [ZS_W-1:0] zs;
    zs = ZS_W'(z) >> Z_SHIFT;
    if (zs > ZS_W'({Z_W{1'b1}})) return '1;
    return zs[Z_W-1:0];
  endfunction

  always_comb begin
    any_z_nonpos = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (in_vert[i][WC_W-1] || (in_vert[i][WC_W-1:0] == '0)) any_z_nonpos = 1'b1;
    end
  end

  // Idle divider operands are 0/1 so the divider never sees a zero divisor.
  always_comb begin
    case (vidx_q)
      2'd1:    cur_vert = world_q[1];
      2'd2:    cur_vert = world_q[2];
      default: cur_vert = world_q[0];
    endcase
    div_x = '0;
    div_y = '0;
    div_z = WC_W'(1);
    if (state_q == ST_ISSUE) begin
      div_x = cur_vert[VERT_W-1 -: WC_W];
      div_y = cur_vert[2*WC_W-1 -: WC_W];
      div_z = cur_vert[WC_W-1:0];
    end
  end

  proj_divider #(.WC_W(WC_W), .DIV_LAT(DIV_LAT)) u_div_x (
    .clk_i (BOARD_CLK),
    .num_i (div_x),
    .den_i (div_z),
    .quo_o (qx)
  );

  proj_divider #(.WC_W(WC_W), .DIV_LAT(DIV_LAT)) u_div_y (
    .clk_i (BOARD_CLK),
    .num_i (div_y),
    .den_i (div_z),
    .quo_o (qy)
  );

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bx[i] = BIN_W'(sx_q[i] >> BIN_SHIFT);
      by[i] = BIN_W'(sy_q[i] >> BIN_SHIFT);
      rv[i] = {sx_q[i], sy_q[i], depth_of(world_q[i][WC_W-1:0])};
    end
    bx_min = bx[0];
    bx_max = bx[0];
    by_min = by[0];
    by_max = by[0];
    for (int i = 1; i < 3; i++) begin
      if (bx[i] < bx_min) bx_min = bx[i];
      if (bx[i] > bx_max) bx_max = bx[i];
      if (by[i] < by_min) by_min = by[i];
      if (by[i] > by_max) by_max = by[i];
    end
  end

  always_comb begin
    state_d = state_q;
    vidx_d  = vidx_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        vidx_d = '0;
        if (in_valid) state_d = any_z_nonpos ? ST_OUT : ST_ISSUE;
      end
      ST_ISSUE: begin
        vidx_d = vidx_q + 2'd1;
        if (vidx_q == 2'd2) begin
          state_d = ST_WAIT;
          wait_d  = WT_W'(DIV_LAT - 1);
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == '0) state_d = ST_BBOX;
      end
      ST_BBOX: state_d = ST_OUT;
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge BOARD_CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vidx_q     <= '0;
      wait_q     <= '0;
      world_q    <= '0;
      last_q     <= 1'b0;
      tag_vld_q  <= '0;
      for (int i = 0; i < DIV_LAT; i++) tag_idx_q[i] <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      out_vert_q <= '0;
      out_bbox_q <= '0;
      out_cull_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vidx_q  <= vidx_d;
      wait_q  <= wait_d;

      // Tag travels alongside the divider pipeline to say which vertex lands.
      tag_vld_q[0] <= (state_q == ST_ISSUE);
      tag_idx_q[0] <= vidx_q;
      for (int i = 1; i < DIV_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      if (tag_vld_q[DIV_LAT-1]) begin
        sx_q[tag_idx_q[DIV_LAT-1]] <= sat_xy(qx, X_OFF);
        sy_q[tag_idx_q[DIV_LAT-1]] <= sat_xy(qy, Y_OFF);
      end

      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            world_q <= in_vert;
            last_q  <= in_last;
            if (any_z_nonpos) begin
              out_cull_q <= 1'b1;
              out_last_q <= in_last;
            end
          end
        end
        ST_BBOX: begin
          out_vert_q <= rv;
          out_bbox_q <= {bx_min, bx_max, by_min, by_max};
          out_cull_q <= 1'b0;
          out_last_q <= last_q;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_vert_q <= '0;
            out_bbox_q <= '0;
            out_cull_q <= 1'b0;
            out_last_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_vert  = out_vert_q;
  assign out_bbox  = out_bbox_q;
  assign out_cull  = out_cull_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_vertex_project_stream.sv
module tb_vertex_project_stream;
  import typhoon_pkg::*;

  logic              BOARD_CLK = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0][62:0]  in_vert;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [2:0][35:0]  out_vert;
  logic [27:0]       out_bbox;
  logic              out_cull;
  logic              out_last;

  vertex_project_stream dut (
    .BOARD_CLK (BOARD_CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vert   (in_vert),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vert  (out_vert),
    .out_bbox  (out_bbox),
    .out_cull  (out_cull),
    .out_last  (out_last)
  );

  always #5 BOARD_CLK = ~BOARD_CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge BOARD_CLK) cyc <= cyc + 1;

  typedef struct {
    logic [107:0] ov;
    logic [27:0]  bb;
    logic         cull;
    logic         last;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  int           rise_log[$];
  int           rise_cyc = 0;
  logic         prev_valid = 1'b0;
  int           tx[3], ty[3], tz[3];
  logic [107:0] e_ov;
  logic [27:0]  e_bb;
  logic         e_cull;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference projection of tx/ty/tz into e_ov/e_bb/e_cull.
  task automatic model();
    raster_vert_t r;
    bbox_t        b;
    int sx, sy, d, bxmin, bxmax, bymin, bymax;
    e_cull = 1'b0;
    for (int i = 0; i < 3; i++) if (tz[i] <= 0) e_cull = 1'b1;
    e_ov = '0;
    e_bb = '0;
    if (!e_cull) begin
      bxmin = 127; bxmax = 0; bymin = 127; bymax = 0;
      for (int i = 0; i < 3; i++) begin
        sx = clampi(tx[i] / tz[i] + 400, 1023);
        sy = clampi(ty[i] / tz[i] + 262, 1023);
        d  = clampi(tz[i] / 32, 65535);
        r.sx = 10'(sx); r.sy = 10'(sy); r.depth = 16'(d);
        e_ov[i*36 +: 36] = r;
        if (sx / 8 < bxmin) bxmin = sx / 8;
        if (sx / 8 > bxmax) bxmax = sx / 8;
        if (sy / 8 < bymin) bymin = sy / 8;
        if (sy / 8 > bymax) bymax = sy / 8;
      end
      b.x_min = 7'(bxmin); b.x_max = 7'(bxmax); b.y_min = 7'(bymin); b.y_max = 7'(bymax);
      e_bb = b;
    end
  endtask

  task automatic drive_vert();
    world_vert_t w;
    for (int i = 0; i < 3; i++) begin
      w.x = 21'(tx[i]); w.y = 21'(ty[i]); w.z = 21'(tz[i]);
      in_vert[i] = w;
    end
  endtask

  task automatic set_tri(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
    tx[0] = x0; ty[0] = y0; tz[0] = z0;
    tx[1] = x1; ty[1] = y1; tz[1] = z1;
    tx[2] = x2; ty[2] = y2; tz[2] = z2;
  endtask

  // Offer the current triangle; record the expectation at the accept cycle.
  task automatic send(input logic last);
    bit ok;
    ok = 0;
    drive_vert();
    in_valid = 1'b1;
    in_last  = last;
    for (int k = 0; k < 200; k++) begin
      @(negedge BOARD_CLK);
      if (in_ready) begin ok = 1; break; end
    end
    check("accept_timeout", ok, 1);
    if (ok) sb.push_back('{e_ov, e_bb, e_cull, last, cyc});
    @(posedge BOARD_CLK); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge BOARD_CLK);
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic sync();
    @(posedge BOARD_CLK); #1;
  endtask

  // Output monitor: pop and compare on every transfer.
  always @(negedge BOARD_CLK) begin
    exp_t e;
    if (out_valid && !prev_valid) begin
      rise_cyc = cyc;
      rise_log.push_back(cyc);
    end
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      check("sb_empty_on_output", (sb.size() == 0), 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_vert", out_vert, e.ov);
        check("out_bbox", out_bbox, e.bb);
        check("out_cull", out_cull, e.cull);
        check("out_last", out_last, e.last);
        check("latency", rise_cyc - e.acc, e.cull ? 1 : 8);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [144:0] snap;
    bit           seen;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; in_vert = '0;
    repeat (3) @(posedge BOARD_CLK);
    #1 reset = 1'b0;
    @(negedge BOARD_CLK);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_vert", out_vert, 0);
    check("rst_out_bbox", out_bbox, 0);
    check("rst_out_cull", out_cull, 0);
    check("rst_out_last", out_last, 0);
    sync();

    // Reference triangle with hand-derived results.
    set_tri(1000, 1500, 10, 125, 100, 1, 200, 250, 2);
    e_ov = {10'd500, 10'd387, 16'd0, 10'd525, 10'd362, 16'd0, 10'd500, 10'd412, 16'd0};
    e_bb = {7'd62, 7'd65, 7'd45, 7'd51};
    e_cull = 1'b0;
    send(0); drain(); sync();

    // Cull: z = 0, then z = -4.
    set_tri(10, 20, 5, 30, 40, 0, 50, 60, 7);
    model(); send(0); drain(); sync();
    set_tri(10, 20, 5, 30, 40, 6, 50, 60, -4);
    model(); send(1); drain(); sync();

    // Saturation high/low and depth = 1.
    set_tri(200000, 0, 1, -200000, 0, 1, 0, 0, 32);
    e_ov = {10'd400, 10'd262, 16'd1, 10'd0, 10'd262, 16'd0, 10'd1023, 10'd262, 16'd0};
    e_bb = {7'd0, 7'd127, 7'd32, 7'd32};
    e_cull = 1'b0;
    send(0); drain(); sync();

    // Degenerate triangle, then truncation toward zero and larger depths.
    set_tri(300, -90, 3, 300, -90, 3, 300, -90, 3);
    model(); send(0); drain(); sync();
    set_tri(-7, 7, 2, 64, -64, 64, 5000, -5000, 4000);
    model(); send(0); drain(); sync();

    // Back-pressure: hold out_ready low with a second triangle pending.
    out_ready = 1'b0;
    set_tri(800, 400, 4, -800, -400, 4, 0, 900, 3);
    model(); send(0);
    set_tri(50, 60, 1, 70, 80, 1, 90, 100, 1);
    model(); drive_vert(); in_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge BOARD_CLK);
      if (out_valid) begin seen = 1; break; end
    end
    check("bp_rise", seen, 1);
    snap = {out_vert, out_bbox, out_cull, out_last, out_valid};
    repeat (20) begin
      @(negedge BOARD_CLK);
      check("bp_hold", {out_vert, out_bbox, out_cull, out_last, out_valid}, snap);
      check("bp_in_ready", in_ready, 0);
    end
    sync();
    out_ready = 1'b1;
    send(0); drain(); sync();

    // Reset in WAIT discards in-flight work.
    set_tri(100, 100, 2, 200, 200, 2, 300, 300, 2);
    model(); send(0);
    repeat (4) @(posedge BOARD_CLK);
    #1 reset = 1'b1;
    sync();
    reset = 1'b0;
    sb.delete();
    @(negedge BOARD_CLK);
    check("wrst_in_ready", in_ready, 1);
    check("wrst_out_valid", out_valid, 0);
    check("wrst_out_vert", out_vert, 0);
    check("wrst_out_bbox", out_bbox, 0);
    check("wrst_out_cull", out_cull, 0);
    check("wrst_out_last", out_last, 0);
    seen = 0;
    repeat (12) begin
      @(negedge BOARD_CLK);
      if (out_valid) seen = 1;
    end
    check("wrst_no_stale_out", seen, 0);
    sync();
    set_tri(-1000, 1000, 5, 1000, -1000, 5, 40, 40, 10);
    model(); send(0); drain(); sync();

    // Stream of four with out_ready high; last flagged on the fourth.
    rise_log.delete();
    for (int t = 0; t < 4; t++) begin
      set_tri(37 * t - 100, 20 * t, t + 1, 300 - 90 * t, -45 * t, 2, 15 * t, 500 - 60 * t, 3 + t);
      model();
      send(t == 3);
    end
    drain();
    check("stream_count", rise_log.size(), 4);
    for (int i = 1; i < rise_log.size(); i++) check("stream_spacing", rise_log[i] - rise_log[i-1], 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
